// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a 4x4 active-low keypad and emits debounced key codes.
module keypad_matrix_scanner #(
  parameter int SCAN_TICKS     = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int TW = $clog2(SCAN_TICKS);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  // nibble {r,c} holds the code of the key at row r, column c
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic {IDLE, PRESSED} state_t;
  state_t state, state_nx;
  logic [3:0] row_s1, row_s2, acc_code, prev_code, res_code, col_code;
  logic [TW-1:0] tick;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] c, low_r;
  logic acc_hit, prev_hit, res_hit, keep_acc, slot_end, scan_end, same, stable, load;
  always_comb begin
    slot_end = tick == TW'(SCAN_TICKS - 1);
    scan_end = slot_end && c == 2'd3;
    low_r    = !row_s2[0] ? 2'd0 : !row_s2[1] ? 2'd1 : !row_s2[2] ? 2'd2 : 2'd3;
    col_code = KEY_MAP[{low_r, c, 2'b00} +: 4];
    keep_acc = c != 2'd0 && acc_hit;
    res_hit  = keep_acc || row_s2 != 4'hF;
    res_code = keep_acc ? acc_code : col_code;
    same     = res_hit == prev_hit && (!res_hit || res_code == prev_code);
    cnt_nx   = !same ? CW'(1) : cnt == CW'(DEBOUNCE_SCANS) ? cnt : cnt + CW'(1);
    stable   = scan_end && cnt_nx == CW'(DEBOUNCE_SCANS);
  end
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    if (stable) begin
      if (state == IDLE && res_hit) begin
        state_nx = PRESSED;
        load     = 1'b1;
      end else if (state == PRESSED && !res_hit) begin
        state_nx = IDLE;
      end else if (state == PRESSED && res_code != key_code) begin
        load = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row_s1    <= 4'hF;
      row_s2    <= 4'hF;
      tick      <= '0;
      c         <= 2'd0;
      col       <= 4'b1110;
      acc_hit   <= 1'b0;
      acc_code  <= 4'h0;
      prev_hit  <= 1'b0;
      prev_code <= 4'h0;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      row_s1    <= row;
      row_s2    <= row_s1;
      tick      <= slot_end ? '0 : tick + TW'(1);
      c         <= c + 2'(slot_end);
      col       <= slot_end ? {col[2:0], col[3]} : col;
      key_valid <= load;
      if (slot_end) begin
        acc_hit  <= res_hit;
        acc_code <= res_code;
      end
      if (scan_end) begin
        prev_hit  <= res_hit;
        prev_code <= res_code;
        cnt       <= cnt_nx;
      end
      if (load) key_code <= res_code;
    end
  end
  assign key_held = state == PRESSED;
endmodule
